// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// master drives the request side, slave (the subtractor) returns the result.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, d, bout, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, d, bout, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor d = a - b: one full-subtractor cell, LSB first,
// one bit per clock, behind a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one difference bit per cycle, WIDTH cycles
// FIN   | result presented, done pulses, then back to IDLE
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] FIN   = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             zero_q;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        d_bit    = a_sh[0] ^ b_sh[0] ^ borrow;
        br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
        res_next = {d_bit, res[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        res    <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res    <= res_next;
                    borrow <= br_next;
                    cnt    <= cnt + 1'b1;
                    // Result registers load on entry to FIN so they are already valid while done is high.
                    if (cnt == CW'(WIDTH - 1)) begin
                        d_q    <= res_next;
                        bout_q <= br_next;
                        zero_q <= (res_next == '0);
                        state  <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == FIN);
    assign bus.d    = d_q;
    assign bus.bout = bout_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4: handshake timing, borrow/zero
// corner cases, held start, async reset abort and an exhaustive operand sweep.
module tb_serial_subtractor;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    serial_subtractor_if #(.WIDTH(4)) bus ();

    serial_subtractor #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle again.
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                          input logic [3:0] ed, input logic eb, input logic ez,
                          input string tag);
        int lat;
        int busy_n;
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
        lat    = 1;
        busy_n = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (bus.busy) busy_n++;
        chk({tag, " latency"}, 32'(lat), 32'd5);
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'd5);
        chk({tag, " d"}, 32'(bus.d), 32'(ed));
        chk({tag, " bout"}, 32'(bus.bout), 32'(eb));
        chk({tag, " zero"}, 32'(bus.zero), 32'(ez));
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, " busy_after"}, 32'(bus.busy), 32'd0);
        chk({tag, " d_hold"}, 32'(bus.d), 32'(ed));
    endtask

    initial begin
        int k;
        int first;
        int second;
        int pulses;
        logic [3:0] ed;
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (2) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset d", 32'(bus.d), 32'd0);
        chk("reset bout", 32'(bus.bout), 32'd0);
        chk("reset zero", 32'(bus.zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle no start", 32'(bus.busy), 32'd0);

        run_op(4'd9,  4'd5,  4'd4,  1'b0, 1'b0, "9-5");
        run_op(4'd3,  4'd7,  4'd12, 1'b1, 1'b0, "3-7");
        run_op(4'd0,  4'd1,  4'd15, 1'b1, 1'b0, "0-1");
        run_op(4'd15, 4'd15, 4'd0,  1'b0, 1'b1, "15-15");
        run_op(4'd0,  4'd0,  4'd0,  1'b0, 1'b1, "0-0");

        // start held high, operands changed mid-operation
        bus.start = 1'b1;
        bus.a     = 4'd9;
        bus.b     = 4'd5;
        @(negedge clk);
        k      = 1;
        first  = 0;
        second = 0;
        while (k < 30) begin
            if (k == 2) begin
                bus.a = 4'd10;
                bus.b = 4'd3;
            end
            if (bus.done) begin
                if (first == 0) begin
                    first = k;
                    chk("hold first d", 32'(bus.d), 32'd4);
                end else begin
                    second = k;
                    chk("hold second d", 32'(bus.d), 32'd7);
                    bus.start = 1'b0;
                    break;
                end
            end
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        chk("hold first latency", 32'(first), 32'd5);
        chk("hold done spacing", 32'(second - first), 32'd6);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        chk("hold no extra op", 32'(pulses), 32'd0);

        // async reset in the second SHIFT cycle
        bus.start = 1'b1;
        bus.a     = 4'd9;
        bus.b     = 4'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort d", 32'(bus.d), 32'd0);
        chk("abort bout", 32'(bus.bout), 32'd0);
        chk("abort zero", 32'(bus.zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        chk("abort no done", 32'(pulses), 32'd0);
        run_op(4'd6, 4'd2, 4'd4, 1'b0, 1'b0, "post-reset 6-2");

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                ed = 4'(ia - ib);
                run_op(4'(ia), 4'(ib), ed, (ia < ib), (ed == 4'd0), "sweep");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
